// File: rtl/calc_sequencer_if.sv
// Handshake bundle between the calculator sequencer and the shared
// multi-cycle arithmetic unit: start pulse plus latched operands going
// out, completion pulse with error qualifier and result coming back.
interface calc_sequencer_if;
    logic       alu_start;
    logic [3:0] operand1;
    logic [3:0] operand2;
    logic [2:0] md_operator;
    logic       alu_done;
    logic       alu_err;
    logic [7:0] alu_result;

    // Sequencer side: drives the start pulse and operands
    modport master (
        output alu_start,
        output operand1,
        output operand2,
        output md_operator,
        input  alu_done,
        input  alu_err,
        input  alu_result
    );

    // Arithmetic unit side
    modport slave (
        input  alu_start,
        input  operand1,
        input  operand2,
        input  md_operator,
        output alu_done,
        output alu_err,
        output alu_result
    );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator sequencing controller: steps through operand / operator
// entry on debounced button presses, launches the arithmetic unit, waits
// for its completion (with timeout), then shows the result for a number
// of 1 s ticks or an error until the user acknowledges.
module calc_sequencer #(
    parameter int SHOW_SECS   = 5,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    tick_1s,
    input  logic [3:0]              num,
    input  logic [1:0]              op,
    input  logic                    mode,
    input  logic                    done,
    calc_sequencer_if.master        alu,
    output logic [7:0]              result,
    output logic [2:0]              state,
    output logic                    calcmod,
    output logic                    show_res,
    output logic                    err,
    output logic                    sof_reset
);

    typedef enum logic [2:0] {
        ST_OP1  = 3'd0,
        ST_OPR  = 3'd1,
        ST_OP2  = 3'd2,
        ST_EXEC = 3'd3,
        ST_SHOW = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam int TMO_W  = $clog2(ALU_TIMEOUT + 1);
    localparam int TICK_W = $clog2(SHOW_SECS + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ALU_TIMEOUT - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SHOW_SECS - 1);
    localparam logic [2:0]        MD_DIVIDE = 3'b011;

    state_t state_reg, state_next;

    logic done_sync1_reg, done_sync2_reg, done_sync3_reg;
    logic done_pulse;

    logic [TMO_W-1:0]  tmo_cnt_reg,  tmo_cnt_next;
    logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;

    logic [3:0] operand1_reg, operand1_next;
    logic [3:0] operand2_reg, operand2_next;
    logic [2:0] md_operator_reg, md_operator_next;
    logic [7:0] result_reg, result_next;
    logic       calcmod_reg, calcmod_next;
    logic       alu_start_reg, alu_start_next;
    logic       show_res_reg, show_res_next;
    logic       err_reg, err_next;
    logic       sof_reset_reg, sof_reset_next;

    logic timeout_hit;
    logic show_expired;

    // Two-flop synchronizer for the raw button plus one flop for edge detect
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            done_sync1_reg <= 1'b0;
            done_sync2_reg <= 1'b0;
            done_sync3_reg <= 1'b0;
        end else begin
            done_sync1_reg <= done;
            done_sync2_reg <= done_sync1_reg;
            done_sync3_reg <= done_sync2_reg;
        end
    end

    // A held button yields a single pulse on its rising edge
    assign done_pulse   = done_sync2_reg & ~done_sync3_reg;
    assign timeout_hit  = (tmo_cnt_reg == TMO_LAST);
    assign show_expired = tick_1s && (tick_cnt_reg == TICK_LAST);

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_OP1;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; alu_done takes priority over a simultaneous timeout
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_OP1: begin
                if (done_pulse) state_next = ST_OPR;
            end
            ST_OPR: begin
                if (done_pulse) state_next = mode ? ST_EXEC : ST_OP2;
            end
            ST_OP2: begin
                if (done_pulse) begin
                    if (md_operator_reg == MD_DIVIDE && num == 4'd0) state_next = ST_ERR;
                    else                                             state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (alu.alu_done)     state_next = alu.alu_err ? ST_ERR : ST_SHOW;
                else if (timeout_hit) state_next = ST_ERR;
            end
            ST_SHOW: begin
                if (done_pulse || show_expired) state_next = ST_OP1;
            end
            ST_ERR: begin
                if (done_pulse) state_next = ST_OP1;
            end
            default: state_next = ST_OP1;
        endcase
    end

    // Next values of the registered outputs and counters
    always_comb begin
        operand1_next    = operand1_reg;
        operand2_next    = operand2_reg;
        md_operator_next = md_operator_reg;
        calcmod_next     = calcmod_reg;
        result_next      = result_reg;
        tmo_cnt_next     = '0;
        tick_cnt_next    = '0;

        if (state_reg == ST_OP1 && done_pulse) begin
            operand1_next = num;
        end
        if (state_reg == ST_OPR && done_pulse) begin
            md_operator_next = {mode, op};
            calcmod_next     = mode;
            if (mode) operand2_next = 4'd0;
        end
        if (state_reg == ST_OP2 && done_pulse) begin
            operand2_next = num;
        end

        // Result only loads on a clean completion; every error entry forces FF
        if (state_reg == ST_EXEC && alu.alu_done && !alu.alu_err) begin
            result_next = alu.alu_result;
        end
        if (state_next == ST_ERR && state_reg != ST_ERR) begin
            result_next = 8'hFF;
        end

        // Counters run only while staying in their state, so they clear on entry
        if (state_reg == ST_EXEC && state_next == ST_EXEC) begin
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
        if (state_reg == ST_SHOW && state_next == ST_SHOW) begin
            tick_cnt_next = tick_1s ? tick_cnt_reg + 1'b1 : tick_cnt_reg;
        end

        alu_start_next = (state_next == ST_EXEC) && (state_reg != ST_EXEC);
        show_res_next  = (state_next == ST_SHOW);
        err_next       = (state_next == ST_ERR);
        sof_reset_next = (state_next == ST_OP1) &&
                         (state_reg == ST_SHOW || state_reg == ST_ERR);
    end

    // Output and counter registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            operand1_reg    <= 4'd0;
            operand2_reg    <= 4'd0;
            md_operator_reg <= 3'd0;
            calcmod_reg     <= 1'b0;
            result_reg      <= 8'd0;
            tmo_cnt_reg     <= '0;
            tick_cnt_reg    <= '0;
            alu_start_reg   <= 1'b0;
            show_res_reg    <= 1'b0;
            err_reg         <= 1'b0;
            sof_reset_reg   <= 1'b0;
        end else begin
            operand1_reg    <= operand1_next;
            operand2_reg    <= operand2_next;
            md_operator_reg <= md_operator_next;
            calcmod_reg     <= calcmod_next;
            result_reg      <= result_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            tick_cnt_reg    <= tick_cnt_next;
            alu_start_reg   <= alu_start_next;
            show_res_reg    <= show_res_next;
            err_reg         <= err_next;
            sof_reset_reg   <= sof_reset_next;
        end
    end

    assign alu.alu_start   = alu_start_reg;
    assign alu.operand1    = operand1_reg;
    assign alu.operand2    = operand2_reg;
    assign alu.md_operator = md_operator_reg;
    assign result          = result_reg;
    assign state           = state_reg;
    assign calcmod         = calcmod_reg;
    assign show_res        = show_res_reg;
    assign err             = err_reg;
    assign sof_reset       = sof_reset_reg;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against
// a behavioural model of the sequencing rules.
module tb_calc_sequencer;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1s = 1'b0;
    logic [3:0] num = 4'd0;
    logic [1:0] op = 2'd0;
    logic       mode = 1'b0;
    logic       done = 1'b0;
    logic [7:0] result;
    logic [2:0] state;
    logic       calcmod, show_res, err, sof_reset;

    calc_sequencer_if alu_bus ();

    calc_sequencer #(.SHOW_SECS(5), .ALU_TIMEOUT(64)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .tick_1s   (tick_1s),
        .num       (num),
        .op        (op),
        .mode      (mode),
        .done      (done),
        .alu       (alu_bus.master),
        .result    (result),
        .state     (state),
        .calcmod   (calcmod),
        .show_res  (show_res),
        .err       (err),
        .sof_reset (sof_reset)
    );

    always #5 CLK = ~CLK;

    // Behavioural model
    int         m_state;
    int         m_exec_cycles;
    int         m_ticks;
    logic [3:0] m_op1, m_op2;
    logic [2:0] m_md;
    logic [7:0] m_res;
    bit         m_cal, m_start, m_sof;
    bit         done_hist[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_exec_cycles = 0; m_ticks = 0;
        m_op1 = 0; m_op2 = 0; m_md = 0; m_res = 0;
        m_cal = 0; m_start = 0; m_sof = 0;
        done_hist = '{0, 0, 0, 0};
    endtask

    task automatic enter_exec();
        m_state = 3; m_start = 1; m_exec_cycles = 0;
    endtask

    task automatic enter_err();
        m_state = 5; m_res = 8'hFF;
    endtask

    // Model of one clock edge: a press first sampled at edge k acts at edge k+2
    task automatic model_edge();
        bit pulse;
        done_hist.push_front(done);
        void'(done_hist.pop_back());
        pulse = done_hist[2] && !done_hist[3];
        m_start = 0;
        m_sof   = 0;
        case (m_state)
            0: if (pulse) begin m_op1 = num; m_state = 1; end
            1: if (pulse) begin
                m_md = {mode, op}; m_cal = mode;
                if (mode) begin m_op2 = 0; enter_exec(); end
                else m_state = 2;
            end
            2: if (pulse) begin
                m_op2 = num;
                if (m_md == 3 && num == 0) enter_err();
                else enter_exec();
            end
            3: begin
                m_exec_cycles++;
                if (alu_bus.alu_done) begin
                    if (alu_bus.alu_err) enter_err();
                    else begin m_res = alu_bus.alu_result; m_state = 4; m_ticks = 0; end
                end else if (m_exec_cycles == 64) enter_err();
            end
            4: begin
                if (tick_1s) m_ticks++;
                if (pulse || m_ticks == 5) begin m_state = 0; m_sof = 1; end
            end
            5: if (pulse) begin m_state = 0; m_sof = 1; end
            default: m_state = 0;
        endcase
    endtask

    task automatic compare_all();
        chk("state",       int'(state),               m_state);
        chk("operand1",    int'(alu_bus.operand1),    int'(m_op1));
        chk("operand2",    int'(alu_bus.operand2),    int'(m_op2));
        chk("md_operator", int'(alu_bus.md_operator), int'(m_md));
        chk("result",      int'(result),              int'(m_res));
        chk("calcmod",     int'(calcmod),             int'(m_cal));
        chk("show_res",    int'(show_res),            (m_state == 4) ? 1 : 0);
        chk("err",         int'(err),                 (m_state == 5) ? 1 : 0);
        chk("alu_start",   int'(alu_bus.alu_start),   int'(m_start));
        chk("sof_reset",   int'(sof_reset),           int'(m_sof));
    endtask

    // One clock: model follows the edge, DUT checked on the falling edge
    task automatic step();
        @(posedge CLK);
        if (!reset) model_reset();
        else        model_edge();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic press(input logic [3:0] n, input logic md, input logic [1:0] o);
        num = n; mode = md; op = o;
        done = 1'b1; step();
        done = 1'b0; step();
        step();
    endtask

    int hold;

    initial begin
        alu_bus.alu_done   = 1'b0;
        alu_bus.alu_err    = 1'b0;
        alu_bus.alu_result = 8'd0;
        model_reset();
        step(); step();
        chk("rst_state", int'(state), 0);
        chk("rst_result", int'(result), 0);
        reset = 1'b1;
        step();

        // Binary add 5 + 3
        press(4'd5, 1'b0, 2'd0);
        chk("add_opr", int'(state), 1);
        chk("add_op1", int'(alu_bus.operand1), 5);
        press(4'd0, 1'b0, 2'd0);
        chk("add_op2st", int'(state), 2);
        press(4'd3, 1'b0, 2'd0);
        chk("add_exec", int'(state), 3);
        chk("add_start", int'(alu_bus.alu_start), 1);
        step(); step();
        alu_bus.alu_done = 1'b1; alu_bus.alu_result = 8'd8;
        step();
        alu_bus.alu_done = 1'b0;
        chk("add_show", int'(state), 4);
        chk("add_result", int'(result), 8);
        chk("add_operand2", int'(alu_bus.operand2), 3);
        chk("add_show_res", int'(show_res), 1);
        for (int i = 0; i < 5; i++) begin
            tick_1s = 1'b1; step();
            tick_1s = 1'b0;
            if (i < 4) step();
        end
        chk("add_back_op1", int'(state), 0);
        chk("add_sof", int'(sof_reset), 1);
        step();
        chk("add_sof_clear", int'(sof_reset), 0);
        chk("add_result_held", int'(result), 8);

        // Unary path, then timeout
        press(4'd4, 1'b0, 2'd0);
        press(4'd0, 1'b1, 2'd1);
        chk("un_exec", int'(state), 3);
        chk("un_op2", int'(alu_bus.operand2), 0);
        chk("un_md", int'(alu_bus.md_operator), 5);
        chk("un_calcmod", int'(calcmod), 1);
        repeat (63) step();
        chk("tmo_still_exec", int'(state), 3);
        step();
        chk("tmo_err", int'(state), 5);
        chk("tmo_result", int'(result), 255);
        chk("tmo_err_flag", int'(err), 1);
        press(4'd0, 1'b0, 2'd0);
        chk("tmo_ack", int'(state), 0);
        chk("tmo_sof", int'(sof_reset), 1);

        // Divide by zero
        press(4'd7, 1'b0, 2'd0);
        press(4'd0, 1'b0, 2'd3);
        press(4'd0, 1'b0, 2'd0);
        chk("div0_err", int'(state), 5);
        chk("div0_nostart", int'(alu_bus.alu_start), 0);
        chk("div0_result", int'(result), 255);
        press(4'd0, 1'b0, 2'd0);
        chk("div0_ack", int'(state), 0);

        // ALU error qualifier
        press(4'd2, 1'b0, 2'd0);
        press(4'd0, 1'b0, 2'd0);
        press(4'd1, 1'b0, 2'd0);
        alu_bus.alu_done = 1'b1; alu_bus.alu_err = 1'b1; alu_bus.alu_result = 8'h42;
        step();
        alu_bus.alu_done = 1'b0; alu_bus.alu_err = 1'b0;
        chk("aerr_state", int'(state), 5);
        chk("aerr_result", int'(result), 255);
        press(4'd0, 1'b0, 2'd0);

        // Held button advances once; presses in EXEC ignored
        num = 4'd9; done = 1'b1;
        repeat (100) step();
        done = 1'b0; step(); step();
        chk("hold_single", int'(state), 1);
        press(4'd0, 1'b0, 2'd2);
        press(4'd6, 1'b0, 2'd0);
        press(4'd0, 1'b0, 2'd0);
        chk("exec_press_ignored", int'(state), 3);
        alu_bus.alu_done = 1'b1; alu_bus.alu_result = 8'h21;
        step();
        alu_bus.alu_done = 1'b0;
        chk("hold_show", int'(state), 4);
        repeat (4) begin
            tick_1s = 1'b1; step();
            tick_1s = 1'b0; step();
        end
        chk("four_ticks", int'(state), 4);
        done = 1'b1; step();
        done = 1'b0; step();
        tick_1s = 1'b1; step();
        tick_1s = 1'b0;
        chk("tick_press_op1", int'(state), 0);
        chk("tick_press_sof", int'(sof_reset), 1);
        step();
        chk("tick_press_once", int'(state), 0);
        chk("tick_press_sof_clear", int'(sof_reset), 0);

        // Reset mid-EXEC
        press(4'd3, 1'b0, 2'd0);
        press(4'd0, 1'b0, 2'd1);
        press(4'd2, 1'b0, 2'd0);
        step();
        #2 reset = 1'b0;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_result", int'(result), 0);
        chk("arst_op1", int'(alu_bus.operand1), 0);
        chk("arst_md", int'(alu_bus.md_operator), 0);
        model_reset();
        step();
        reset = 1'b1;
        alu_bus.alu_done = 1'b1; alu_bus.alu_result = 8'h55;
        step();
        alu_bus.alu_done = 1'b0;
        chk("late_done_state", int'(state), 0);
        chk("late_done_result", int'(result), 0);

        // Randomized traffic
        hold = 0;
        for (int c = 0; c < 6000; c++) begin
            if (hold == 0) begin
                done = $urandom_range(0, 1) == 1;
                hold = $urandom_range(1, 6);
            end
            hold--;
            num  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            op   = 2'($urandom);
            mode = ($urandom_range(0, 3) == 0);
            tick_1s = ($urandom_range(0, 5) == 0);
            alu_bus.alu_done   = ($urandom_range(0, 29) == 0);
            alu_bus.alu_err    = ($urandom_range(0, 3) == 0);
            alu_bus.alu_result = 8'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Sequencing controller for the calculator datapath. It walks the user through operand and operator entry on debounced `done` presses, issues a start pulse to the shared multi-cycle arithmetic unit and waits for its completion handshake. It then holds the result for display for a programmable number of 1 s ticks and returns to entry. It sits between the switch/button inputs and the arithmetic unit, and drives `state`, `calcmod` and `show_res` to the segment display.

## Interface
- `SHOW_SECS`, default 5: number of `tick_1s` pulses the result is shown before auto-return to entry (≥1).
- `ALU_TIMEOUT`, default 64: cycles allowed in EXEC without `alu_done` before ERR (≥2).
- `CLK` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low; all registers take reset values immediately.
- `tick_1s` in 1: one-cycle pulse per second from the clock divider, synchronous to `CLK`.
- `num` in 4: operand switches.
- `op` in 2: operator switches.
- `mode` in 1: 0 = binary (basic) operator, 1 = unary (scientific) operator.
- `done` in 1: raw push button, asynchronous, level.
- `alu_done` in 1: one-cycle completion pulse from the arithmetic unit.
- `alu_err` in 1: error qualifier, valid only when `alu_done`=1.
- `alu_result` in 8: result, valid only when `alu_done`=1.
- `alu_start` out 1: one-cycle start pulse to the arithmetic unit.
- `operand1`, `operand2` out 4 each: latched operands.
- `md_operator` out 3: latched `{mode, op}`.
- `result` out 8: latched result.
- `state` out 3: current state encoding.
- `calcmod` out 1: latched mode.
- `show_res` out 1: high in SHOW.
- `err` out 1: high in ERR.
- `sof_reset` out 1: one-cycle soft-reset pulse to the downstream datapath.

## Operation
- `done` input conditioning:
  - `done` passes through a 2-flop synchronizer, then a third flop for edge detection.
  - `done_pulse` = sync2 & ~sync3, one cycle per press.
  - Holding the button produces only one pulse.
- State encoding: OP1=0, OPR=1, OP2=2, EXEC=3, SHOW=4, ERR=5. Codes 6 and 7 go to OP1 on the next edge.
- OP1: on `done_pulse`, `operand1`←`num`; go to OPR.
- OPR: on `done_pulse`, `md_operator`←`{mode,op}` and `calcmod`←`mode`.
  - If `mode`=1: `operand2`←0 and go to EXEC.
  - If `mode`=0: go to OP2.
- OP2: on `done_pulse`, `operand2`←`num`.
  - If `md_operator`=3'b011 (divide) and `num`=0: go to ERR.
  - Otherwise: go to EXEC.
- EXEC:
  - `alu_start`=1 for exactly the first cycle in EXEC.
  - A timeout counter clears on entry and increments every cycle in EXEC.
  - `done_pulse` is ignored.
  - On `alu_done` with `alu_err`=0: `result`←`alu_result`; go to SHOW.
  - On `alu_done` with `alu_err`=1: go to ERR.
  - If no `alu_done` after `ALU_TIMEOUT` cycles in EXEC: go to ERR.
  - `alu_done` in the same cycle as timeout expiry: `alu_done` wins.
- SHOW:
  - `show_res`=1; a tick counter clears on entry.
  - On the `SHOW_SECS`-th `tick_1s`, or on `done_pulse` (whichever comes first; both in the same cycle is one transition): go to OP1 and pulse `sof_reset`.
  - `result` is held into OP1 and updates only on the next successful EXEC.
- ERR:
  - `err`=1 and `result`←8'hFF on entry.
  - Leaves only on `done_pulse`: go to OP1 and pulse `sof_reset`.
  - `tick_1s` is ignored.
- `alu_done` outside EXEC is ignored.

## Timing
- Reset values: `state`=0 (OP1); `operand1`, `operand2`, `md_operator`, `result`, `calcmod` all 0; `show_res`, `err`, `alu_start`, `sof_reset` all 0; all counters and synchronizer flops 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Press latency: if `done` is first sampled high at edge k, the state and latched values change at edge k+2.
- `alu_start` is high from the edge entering EXEC until the following edge.
- Result latency: `result` and `state`=SHOW update at the edge that samples `alu_done`.
- Timeout: with no `alu_done`, `state`=ERR is visible exactly `ALU_TIMEOUT` edges after EXEC entry.
- `sof_reset` is high for the one cycle following the edge that enters OP1 from SHOW or ERR.
- Reset asserted mid-operation (any state, including EXEC with the arithmetic unit busy): immediate return to reset values. A late `alu_done` after reset is ignored because the state is OP1.

## Test plan
- Binary add:
  - Stimulus: reset; press with `num`=5; press with `mode`=0, `op`=00; press with `num`=3; `alu_done` with `alu_result`=8 two cycles after `alu_start`.
  - Required: `state` sequence 0,1,2,3,4; `operand1`=5, `operand2`=3, `md_operator`=000, `result`=8, `show_res`=1.
  - Then after 5 `tick_1s` pulses: OP1 with a one-cycle `sof_reset`.
- Unary path:
  - Stimulus: press with `num`=4; press with `mode`=1, `op`=01.
  - Required: OP2 is skipped; EXEC reached with `operand2`=0, `md_operator`=101, `calcmod`=1.
- Divide by zero:
  - Stimulus: `op`=11, `mode`=0, second operand 0.
  - Required: ERR directly from OP2; no `alu_start`; `result`=FF, `err`=1. One press → OP1 plus `sof_reset`.
- Timeout and `alu_err`:
  - Stimulus: no `alu_done`.
  - Required: ERR exactly 64 edges after EXEC entry.
  - Separately: `alu_done` with `alu_err`=1 → ERR; `result` is not loaded from `alu_result`.
- Button behaviour:
  - Stimulus: `done` held high for 100 cycles.
  - Required: only one state advance.
  - Presses during EXEC are ignored.
  - A press in SHOW on the same cycle as the 5th tick gives a single return to OP1.
- Reset mid-EXEC:
  - Stimulus: assert `reset` low while in EXEC, then deliver `alu_done`.
  - Required: all outputs return to reset values asynchronously; the later `alu_done` leaves `state`=0 and `result`=0.
